// File: rtl/nbj_fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// nbj_fetch_sequencer_if
//   Bundles the aligner, NBJ, decode and backend-redirect signals around the
//   fetch sequencer.
//
//   Handshake: a fetch group transfers in a cycle where i_groupValid and
//   i_decodeReady are both 1 and the sequencer raises o_groupAccept in the
//   same cycle. The aligner holds the group stable until it is accepted.
//   i_redirectValid is a single-cycle command with no back-pressure.
//
//   Modports:
//     master - environment side (aligner / NBJ / decode / backend)
//     slave  - sequencer side
//   dbg_state exposes the sequencer FSM state (0 RUN, 1 WAIT_PRED, 2 FLUSH).
// -----------------------------------------------------------------------------
interface nbj_fetch_sequencer_if #(
    parameter int RAS_DEPTH = 8
);
    localparam int DW = $clog2(RAS_DEPTH) + 1;

    logic          i_groupValid;
    logic [4:0]    i_validSize_5;
    logic          i_hasJump;
    logic [2:0]    i_jumpType_3;
    logic [31:0]   i_predPc_32;
    logic          i_decodeReady;
    logic          i_redirectValid;
    logic [31:0]   i_redirectPc_32;
    logic          o_groupAccept;
    logic          o_fire;
    logic [31:0]   o_fetchPc_32;
    logic          o_flush;
    logic [1:0]    o_pcSource_2;
    logic [DW-1:0] o_rasDepth_4;
    logic          o_rasOverflow;
    logic [1:0]    dbg_state;

    modport master (
        output i_groupValid, i_validSize_5, i_hasJump, i_jumpType_3,
               i_predPc_32, i_decodeReady, i_redirectValid, i_redirectPc_32,
        input  o_groupAccept, o_fire, o_fetchPc_32, o_flush, o_pcSource_2,
               o_rasDepth_4, o_rasOverflow, dbg_state
    );

    modport slave (
        input  i_groupValid, i_validSize_5, i_hasJump, i_jumpType_3,
               i_predPc_32, i_decodeReady, i_redirectValid, i_redirectPc_32,
        output o_groupAccept, o_fire, o_fetchPc_32, o_flush, o_pcSource_2,
               o_rasDepth_4, o_rasOverflow, dbg_state
    );
endinterface

// File: rtl/nbj_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// nbj_fetch_sequencer
//   Front-end fetch loop sequencer. Jump-free groups advance the fetch PC by
//   the group size; groups containing a jump fire a one-cycle strobe to the
//   NBJ logic and take its predicted PC on the following cycle. Backend
//   redirects override everything and open a flush window of FLUSH_CYCLES.
//   A shadow return-address-stack occupancy counter makes call overflow
//   visible through a sticky flag.
//
//   Ports:
//     clk  - clock, all state on rising edge
//     rst  - synchronous active-high reset
//     bus  - nbj_fetch_sequencer_if.slave (group, NBJ, decode, redirect I/O)
// -----------------------------------------------------------------------------
module nbj_fetch_sequencer #(
    parameter int          RAS_DEPTH    = 8,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    nbj_fetch_sequencer_if.slave    bus
);
    localparam int DW = $clog2(RAS_DEPTH) + 1;
    // Counter only ever holds FLUSH_CYCLES-1.
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [2:0] JT_CALL = 3'd4;
    localparam logic [2:0] JT_RET  = 3'd5;

    localparam logic [1:0] SRC_SEQ   = 2'd0;
    localparam logic [1:0] SRC_PRED  = 2'd1;
    localparam logic [1:0] SRC_REDIR = 2'd2;
    localparam logic [1:0] SRC_RESET = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_PRED = 2'd1,
        ST_FLUSH     = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [1:0]    src_q, src_d;
    logic          fire_q, fire_d;
    logic          flush_q, flush_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic [2:0]    jtype_q, jtype_d;
    logic          accept;

    assign accept = (state_q == ST_RUN) & bus.i_groupValid & bus.i_decodeReady
                    & ~bus.i_redirectValid & ~rst;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        src_d   = src_q;
        fire_d  = fire_q;
        flush_d = flush_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        jtype_d = jtype_q;

        // RAS shadow update happens in the fire cycle, independent of any
        // redirect arriving in that same cycle.
        if (fire_q) begin
            if (jtype_q == JT_CALL) begin
                if (depth_q == DW'(RAS_DEPTH)) ovf_d   = 1'b1;
                else                           depth_d = depth_q + 1'b1;
            end else if (jtype_q == JT_RET) begin
                if (depth_q != '0) depth_d = depth_q - 1'b1;
            end
        end

        if (bus.i_redirectValid) begin
            pc_d    = bus.i_redirectPc_32;
            src_d   = SRC_REDIR;
            flush_d = 1'b1;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
            fire_d  = 1'b0;
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (accept) begin
                        if (bus.i_hasJump) begin
                            jtype_d = bus.i_jumpType_3;
                            fire_d  = 1'b1;
                            state_d = ST_WAIT_PRED;
                        end else begin
                            pc_d  = pc_q + {27'd0, bus.i_validSize_5};
                            src_d = SRC_SEQ;
                        end
                    end
                end
                ST_WAIT_PRED: begin
                    pc_d    = bus.i_predPc_32;
                    src_d   = SRC_PRED;
                    fire_d  = 1'b0;
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) begin
                        flush_d = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            src_q   <= SRC_RESET;
            fire_q  <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            jtype_q <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            src_q   <= src_d;
            fire_q  <= fire_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            jtype_q <= jtype_d;
        end
    end

    assign bus.o_groupAccept = accept;
    assign bus.o_fire        = fire_q;
    assign bus.o_fetchPc_32  = pc_q;
    assign bus.o_flush       = flush_q;
    assign bus.o_pcSource_2  = src_q;
    assign bus.o_rasDepth_4  = depth_q;
    assign bus.o_rasOverflow = ovf_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: doc/nbj_fetch_sequencer.md
Name: nbj_fetch_sequencer

Overview:
- Sequences the front-end fetch loop around the non-sequential-jump (NBJ) processing logic.
- Accepts aligned fetch groups from the aligner and advances the fetch PC sequentially for jump-free groups. For groups containing a jump, it issues a one-cycle fire pulse to the NBJ logic and takes its predicted PC.
- Arbitrates these sources against backend redirects, which always win.
- Runs a post-redirect flush window and tracks return-address-stack occupancy so call overflow is visible.

Parameters:
- RAS_DEPTH, 8, number of RAS entries tracked; must be a power of 2 and ≥2.
- FLUSH_CYCLES, 2, number of cycles o_flush stays high after a redirect; must be ≥1.
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- i_groupValid  in  1  aligner presents a fetch group.
- i_validSize_5  in  5  byte size of the presented group (0–31).
- i_hasJump  in  1  group contains a non-sequential jump.
- i_jumpType_3  in  3  type of first jump: 3 = JALR, 4 = CALL, 5 = RET, other values = direct.
- i_predPc_32  in  32  predicted next PC from the NBJ logic; valid while o_fire = 1.
- i_decodeReady  in  1  downstream can take a group this cycle.
- i_redirectValid  in  1  backend misprediction redirect.
- i_redirectPc_32  in  32  corrected PC.
- o_groupAccept  out  1  group handshake completes this cycle (combinational).
- o_fire  out  1  registered one-cycle strobe to the NBJ logic.
- o_fetchPc_32  out  32  current fetch PC (registered).
- o_flush  out  1  registered; kill in-flight front-end state.
- o_pcSource_2  out  2  source of the current o_fetchPc_32: 0 = sequential, 1 = predicted, 2 = redirect, 3 = reset.
- o_rasDepth_4  out  $clog2(RAS_DEPTH)+1  tracked RAS occupancy.
- o_rasOverflow  out  1  sticky; a CALL was fired while the RAS was full.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - state = RUN; o_fetchPc_32 = RESET_PC; o_pcSource_2 = 3.
  - o_fire = 0, o_flush = 0, o_rasDepth_4 = 0, o_rasOverflow = 0, flush counter = 0.
  - o_groupAccept is forced to 0 while rst = 1.
  - Reset mid-operation discards any pending fire or flush immediately.
- States: RUN, WAIT_PRED, FLUSH (2-bit encoding).
- o_groupAccept = (state == RUN) & i_groupValid & i_decodeReady & ~i_redirectValid & ~rst.
- RUN, on accept with i_hasJump = 0:
  - o_fetchPc_32 <= o_fetchPc_32 + zero-extended i_validSize_5, mod 2^32 (wraps 32'hFFFF_FFFC+8 → 32'h4).
  - o_pcSource_2 <= 0; stay in RUN. Latency 1 cycle.
- RUN, on accept with i_hasJump = 1:
  - Latch i_jumpType_3; o_fire <= 1; go to WAIT_PRED.
- WAIT_PRED (o_fire = 1 for exactly this cycle):
  - Sample i_predPc_32: o_fetchPc_32 <= i_predPc_32, o_pcSource_2 <= 1, o_fire <= 0, go to RUN.
  - Jump-group latency from accept to new PC is 2 cycles; no accept occurs in WAIT_PRED.
- RAS tracking, evaluated in the o_fire cycle from the latched type:
  - CALL: depth + 1, saturating at RAS_DEPTH. If depth is already RAS_DEPTH, set o_rasOverflow.
  - RET: depth − 1, saturating at 0.
  - Other types: no change.
  - RAS tracking is not altered by redirects; o_rasOverflow clears only on reset.
- Redirect (i_redirectValid = 1 in any state) has the highest priority:
  - Next cycle: o_fetchPc_32 = i_redirectPc_32, o_pcSource_2 = 2, o_flush = 1, counter = FLUSH_CYCLES − 1, state = FLUSH, o_fire = 0.
  - Redirect during WAIT_PRED: the fire strobe already on the wire completes (RAS update still applies), but i_predPc_32 is ignored.
  - Redirect in the same cycle as a would-be accept: no accept.
- FLUSH:
  - o_flush stays 1 and no accept occurs.
  - Counter decrements each cycle; when it reaches 0, the next cycle sets o_flush = 0 and state = RUN.
  - A new redirect during FLUSH loads the new PC and restarts the counter at FLUSH_CYCLES − 1.
  - o_flush is high for exactly FLUSH_CYCLES cycles per final redirect.
- i_groupValid with i_decodeReady = 0: no state change and the PC holds. The aligner must hold the group stable.

Test Plan:
- Reset then release, group valid+ready, hasJump = 0, size 16 → o_fetchPc_32 0 → 16 → 32 on consecutive cycles, o_pcSource_2 = 0, o_fire never high.
- Group with hasJump = 1, type 4 (CALL), i_predPc_32 = 32'h400 → o_fire high exactly 1 cycle, o_fetchPc_32 = 32'h400 next cycle, o_pcSource_2 = 1, o_rasDepth_4 = 1, no accept during WAIT_PRED.
- Nine CALL groups then one RET → depth saturates at 8, o_rasOverflow = 1 after the 9th and stays 1, depth 7 after the RET. Ten RETs from depth 0 → depth stays 0.
- Redirect to 32'h1000 during WAIT_PRED with i_predPc_32 = 32'h400 → fetch PC = 32'h1000, source 2, o_flush high exactly 2 cycles, no accept until RUN.
- Second redirect to 32'h2000 on flush cycle 1 → PC = 32'h2000, o_flush high 2 further cycles, 3 cycles total.
- Fetch PC 32'hFFFF_FFF8 with size 8 → wraps to 32'h0. Assert rst while in FLUSH → next cycle PC = RESET_PC, o_flush = 0, depth 0, overflow 0.
